// File: rtl/mc_controller_ext.sv
// mc_controller_ext: multicycle RV32I-style control FSM.
// The state register and sticky illegal flag are clocked; all datapath
// controls are decoded from the current state plus op/funct/flag inputs.
// Optional feature: define MC_BRANCH_EXT_EN to enable bne/blt/bge/bltu/bgeu.
// Without it only beq is legal; other branch funct3 values trap in DECODE.
//
// state    | code | meaning
// FETCH    |  0   | read instruction, PC += 4 when memory is ready
// DECODE   |  1   | register read, ALUOut = OldPC + imm
// MEMADR   |  2   | compute load/store address
// MEMREAD  |  3   | load access, wait for memready
// MEMWB    |  4   | write load data to register file
// MEMWRITE |  5   | store access, wait for memready
// EXECUTER |  6   | register-register ALU operation
// EXECUTEI |  7   | register-immediate ALU operation
// ALUWB    |  8   | write ALUOut to register file
// JAL      |  9   | PC = target, ALUOut = OldPC + 4
// JALR     | 10   | compute rs1 + imm target
// JALRPC   | 11   | PC = target, ALUOut = OldPC + 4
// BRANCH   | 12   | compare, PC = target when taken
// LUI      | 13   | ALU = 0 + imm
// AUIPC    | 14   | ALU = OldPC + imm
// TRAP     | 15   | illegal instruction, hold until reset

module mc_controller_ext #(
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 memready,
    output logic [2:0]           immsrc,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           resultsrc,
    output logic                 adrsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 regwrite,
    output logic                 memwrite,
    output logic                 memreq,
    output logic                 illegal,
    output logic [3:0]           state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALRPC   = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;
    aluop_t     aluop;
    logic [3:0] alu_code;
    logic       branch;
    logic       pcupdate;
    logic       taken;
    logic       branch_legal;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       memwrite_raw;
    logic       memreq_raw;

    // Branch condition; the reduced build only understands beq.
`ifdef MC_BRANCH_EXT_EN
    always_comb begin
        taken        = 1'b0;
        branch_legal = 1'b1;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_cmp;
    assign unused_cmp = lt ^ ltu;

    // Only funct3 000 can reach BRANCH; anything else is trapped in DECODE.
    always_comb begin
        taken        = (funct3 == 3'b000) & zero;
        branch_legal = (funct3 == 3'b000);
    end
`endif

    // State register and sticky trap flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) illegal_q <= 1'b1;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (memready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_I:              state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = branch_legal ? S_BRANCH : S_TRAP;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (memready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (memready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRPC;
            S_JALRPC:   state_d = S_ALUWB;
            S_BRANCH:   state_d = S_FETCH;
            S_LUI:      state_d = S_ALUWB;
            S_AUIPC:    state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    // Per-state datapath controls; anything not set stays 0.
    always_comb begin
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        resultsrc    = 2'b00;
        adrsrc       = 1'b0;
        aluop        = ALUOP_ADD;
        branch       = 1'b0;
        pcupdate     = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        memreq_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                memreq_raw  = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                irwrite_raw = memready;
                pcupdate    = memready;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMREAD: begin
                memreq_raw = 1'b1;
                adrsrc     = 1'b1;
            end
            S_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                memreq_raw   = 1'b1;
                memwrite_raw = 1'b1;
                adrsrc       = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB:    regwrite_raw = 1'b1;
            S_JAL, S_JALRPC: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            S_JALR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_BRANCH: begin
                alusrca = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_LUI: begin
                alusrca = 2'b11;
                alusrcb = 2'b01;
            end
            S_AUIPC: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            default: ;
        endcase
    end

    // ALU operation code; sub for funct3 000 only on R-type with funct7b5.
    always_comb begin
        alu_code = 4'd0;
        case (aluop)
            ALUOP_SUB: alu_code = 4'd1;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_code = (op[5] & funct7b5) ? 4'd1 : 4'd0;
                    3'b001:  alu_code = 4'd7;
                    3'b010:  alu_code = 4'd5;
                    3'b011:  alu_code = 4'd6;
                    3'b100:  alu_code = 4'd4;
                    3'b101:  alu_code = funct7b5 ? 4'd9 : 4'd8;
                    3'b110:  alu_code = 4'd3;
                    default: alu_code = 4'd2;
                endcase
            end
            default: alu_code = 4'd0;
        endcase
    end

    // Immediate format depends on the opcode only.
    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: immsrc = 3'b000;
            OP_STORE:               immsrc = 3'b001;
            OP_BRANCH:              immsrc = 3'b010;
            OP_JAL:                 immsrc = 3'b011;
            OP_LUI, OP_AUIPC:       immsrc = 3'b100;
            default:                immsrc = 3'b000;
        endcase
    end

    // Strobes are held off while reset is asserted.
    assign alucontrol = ALUCTRL_W'(alu_code);
    assign irwrite    = irwrite_raw & reset;
    assign pcwrite    = ((branch & taken) | pcupdate) & reset;
    assign regwrite   = regwrite_raw & reset;
    assign memwrite   = memwrite_raw & reset;
    assign memreq     = memreq_raw & reset;
    assign illegal    = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_controller_ext.sv
module tb_mc_controller_ext;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, ltu, memready;
    logic [2:0] immsrc;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic       adrsrc;
    logic [3:0] alucontrol;
    logic       irwrite, pcwrite, regwrite, memwrite, memreq, illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    mc_controller_ext #(.ALUCTRL_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .memready(memready),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb), .resultsrc(resultsrc),
        .adrsrc(adrsrc), .alucontrol(alucontrol), .irwrite(irwrite), .pcwrite(pcwrite),
        .regwrite(regwrite), .memwrite(memwrite), .memreq(memreq), .illegal(illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        int         st;
        int         imm;
        int         alu;
        int         srca;
        int         srcb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [6:0] o, logic [2:0] f, logic s7, int st, int imm,
                                int alu, int sa, int sb);
        vec_t v;
        v.op = o; v.f3 = f; v.f7 = s7; v.st = st; v.imm = imm;
        v.alu = alu; v.srca = sa; v.srcb = sb;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; memready = 1'b0;

        // op, funct3, funct7b5 -> state after DECODE, immsrc, alucontrol, alusrca, alusrcb
        vecs.push_back(mk(7'b0110011, 3'b000, 1'b0, 6, 0, 0, 2, 0));
        vecs.push_back(mk(7'b0110011, 3'b000, 1'b1, 6, 0, 1, 2, 0));
        vecs.push_back(mk(7'b0110011, 3'b101, 1'b1, 6, 0, 9, 2, 0));
        vecs.push_back(mk(7'b0110011, 3'b101, 1'b0, 6, 0, 8, 2, 0));
        vecs.push_back(mk(7'b0110011, 3'b001, 1'b0, 6, 0, 7, 2, 0));
        vecs.push_back(mk(7'b0010011, 3'b000, 1'b1, 7, 0, 0, 2, 1));
        vecs.push_back(mk(7'b0010011, 3'b010, 1'b0, 7, 0, 5, 2, 1));
        vecs.push_back(mk(7'b0010011, 3'b011, 1'b0, 7, 0, 6, 2, 1));
        vecs.push_back(mk(7'b0010011, 3'b100, 1'b0, 7, 0, 4, 2, 1));
        vecs.push_back(mk(7'b0010011, 3'b110, 1'b0, 7, 0, 3, 2, 1));
        vecs.push_back(mk(7'b0010011, 3'b111, 1'b0, 7, 0, 2, 2, 1));
        vecs.push_back(mk(7'b0010011, 3'b101, 1'b1, 7, 0, 9, 2, 1));
        vecs.push_back(mk(7'b0000011, 3'b010, 1'b0, 2, 0, 0, 2, 1));
        vecs.push_back(mk(7'b0100011, 3'b010, 1'b0, 2, 1, 0, 2, 1));
        vecs.push_back(mk(7'b1100011, 3'b000, 1'b0, 12, 2, 1, 2, 0));
        vecs.push_back(mk(7'b1101111, 3'b000, 1'b0, 9, 3, 0, 1, 2));
        vecs.push_back(mk(7'b1100111, 3'b000, 1'b0, 10, 0, 0, 2, 1));
        vecs.push_back(mk(7'b0110111, 3'b000, 1'b0, 13, 4, 0, 3, 1));
        vecs.push_back(mk(7'b0010111, 3'b000, 1'b0, 14, 4, 0, 1, 1));
        vecs.push_back(mk(7'b1111111, 3'b000, 1'b0, 15, 0, 0, 0, 0));
`ifdef MC_BRANCH_EXT_EN
        vecs.push_back(mk(7'b1100011, 3'b001, 1'b0, 12, 2, 1, 2, 0));
`else
        vecs.push_back(mk(7'b1100011, 3'b001, 1'b0, 15, 2, 0, 0, 0));
`endif

        // Reset behaviour and FETCH waiting on memready.
        memready = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_irwrite", irwrite, 0);
        chk("rst_pcwrite", pcwrite, 0);
        chk("rst_memreq", memreq, 0);
        chk("rst_alusrcb", alusrcb, 2);
        chk("rst_resultsrc", resultsrc, 2);
        chk("rst_illegal", illegal, 0);
        @(posedge clk);
        #1;
        memready = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            memready = (i == 3);
            @(negedge clk);
            chk("fetch_wait_state", state, 0);
            chk("fetch_wait_memreq", memreq, 1);
            chk("fetch_wait_irwrite", irwrite, (i == 3) ? 1 : 0);
            chk("fetch_wait_pcwrite", pcwrite, (i == 3) ? 1 : 0);
            next_cyc();
        end
        @(negedge clk);
        chk("fetch_to_decode", state, 1);

        // Table of decode outcomes.
        foreach (vecs[k]) begin
            do_reset();
            op = vecs[k].op; funct3 = vecs[k].f3; funct7b5 = vecs[k].f7;
            memready = 1'b1; zero = 1'b0;
            next_cyc();
            next_cyc();
            @(negedge clk);
            chk($sformatf("vec%0d_state", k), state, vecs[k].st);
            chk($sformatf("vec%0d_immsrc", k), immsrc, vecs[k].imm);
            chk($sformatf("vec%0d_alu", k), alucontrol, vecs[k].alu);
            chk($sformatf("vec%0d_srca", k), alusrca, vecs[k].srca);
            chk($sformatf("vec%0d_srcb", k), alusrcb, vecs[k].srcb);
        end

        // Load with memory always ready.
        begin
            int exp_st[6] = '{0, 1, 2, 3, 4, 0};
            do_reset();
            op = 7'b0000011; funct3 = 3'b010; memready = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("lw_state", state, exp_st[i]);
                chk("lw_regwrite", regwrite, (exp_st[i] == 4) ? 1 : 0);
                if (exp_st[i] == 4) chk("lw_resultsrc", resultsrc, 1);
                if (exp_st[i] == 3) chk("lw_adrsrc", adrsrc, 1);
                next_cyc();
            end
        end

        // Store with memory stalling two cycles.
        do_reset();
        op = 7'b0100011; funct3 = 3'b010; memready = 1'b1;
        next_cyc();
        next_cyc();
        memready = 1'b0;
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            memready = (i == 2);
            @(negedge clk);
            chk("sw_state", state, 5);
            chk("sw_memwrite", memwrite, 1);
            chk("sw_memreq", memreq, 1);
            next_cyc();
        end
        @(negedge clk);
        chk("sw_done_state", state, 0);
        chk("sw_done_memwrite", memwrite, 0);

        // bne taken / not taken.
        for (int z = 0; z < 2; z++) begin
            do_reset();
            op = 7'b1100011; funct3 = 3'b001; memready = 1'b1; zero = (z == 1);
            next_cyc();
            next_cyc();
            @(negedge clk);
`ifdef MC_BRANCH_EXT_EN
            chk("bne_state", state, 12);
            chk("bne_pcwrite", pcwrite, (z == 0) ? 1 : 0);
`else
            chk("bne_state", state, 15);
            chk("bne_illegal", illegal, 1);
            chk("bne_pcwrite", pcwrite, 0);
`endif
        end

        // beq taken / not taken.
        for (int z = 0; z < 2; z++) begin
            do_reset();
            op = 7'b1100011; funct3 = 3'b000; memready = 1'b1; zero = (z == 1);
            next_cyc();
            next_cyc();
            @(negedge clk);
            chk("beq_state", state, 12);
            chk("beq_pcwrite", pcwrite, (z == 1) ? 1 : 0);
            chk("beq_regwrite", regwrite, 0);
            next_cyc();
            @(negedge clk);
            chk("beq_next_state", state, 0);
        end

        // jalr sequence.
        begin
            int exp_st[6] = '{0, 1, 10, 11, 8, 0};
            int exp_pc[6] = '{1, 0, 0, 1, 0, 1};
            do_reset();
            op = 7'b1100111; funct3 = 3'b000; memready = 1'b1; zero = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                chk("jalr_state", state, exp_st[i]);
                chk("jalr_pcwrite", pcwrite, exp_pc[i]);
                chk("jalr_regwrite", regwrite, (exp_st[i] == 8) ? 1 : 0);
                next_cyc();
            end
        end

        // Illegal opcode holds TRAP until an asynchronous reset.
        do_reset();
        op = 7'b1111111; memready = 1'b1;
        next_cyc();
        next_cyc();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("trap_state", state, 15);
            chk("trap_illegal", illegal, 1);
            chk("trap_memreq", memreq, 0);
            next_cyc();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("trap_async_state", state, 0);
        chk("trap_async_illegal", illegal, 0);
        next_cyc();
        reset = 1'b1;

        // Reset during a stalled load abandons the access.
        op = 7'b0000011; memready = 1'b1;
        next_cyc();
        next_cyc();
        memready = 1'b0;
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("ldwait_state", state, 3);
        chk("ldwait_memreq", memreq, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("ldwait_rst_state", state, 0);
        chk("ldwait_rst_memreq", memreq, 0);
        next_cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("ldwait_after_state", state, 0);
        chk("ldwait_after_adrsrc", adrsrc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller_ext.md
MC_CONTROLLER_EXT -- requirements
Module: mc_controller_ext

Interface
REQ-001 Parameter ALUCTRL_W, default 4, sets alucontrol width; minimum 4; codes zero-extended.
REQ-002 Ports: clk in 1 system clock; reset in 1 asynchronous, active-low reset; op in 7 opcode; funct3 in 3; funct7b5 in 1.
REQ-003 Ports: zero in 1 ALU result==0; lt in 1 signed A<B; ltu in 1 unsigned A<B; memready in 1 memory completes access this cycle.
REQ-004 Ports: immsrc out 3 (000 I, 001 S, 010 B, 011 J, 100 U); alusrca out 2 (00 PC, 01 OldPC, 10 rs1, 11 zero); alusrcb out 2 (00 rs2, 01 imm, 10 const 4).
REQ-005 Ports: resultsrc out 2 (00 ALUOut, 01 Data, 10 ALUResult); adrsrc out 1 (0 PC, 1 Result); alucontrol out ALUCTRL_W.
REQ-006 Ports: irwrite, pcwrite, regwrite, memwrite, memreq out 1 each; illegal out 1 sticky trap flag; state out 4 current state code.

Function
REQ-007 States, coded 0-15 in order: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, JALR, JALRPC, BRANCH, LUI, AUIPC, TRAP.
REQ-008 FETCH: memreq=1, adrsrc=0, alusrca=00, alusrcb=10, aluop add, resultsrc=10; irwrite and pcupdate asserted only when memready=1; leave to DECODE only on memready=1, else hold.
REQ-009 DECODE: alusrca=01, alusrcb=01, add (ALUOut=OldPC+imm); next by op: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, any other TRAP.
REQ-010 MEMADR: alusrca=10, alusrcb=01, add; next MEMREAD for loads, MEMWRITE for stores.
REQ-011 MEMREAD: memreq=1, adrsrc=1, resultsrc=00; hold until memready=1, then MEMWB; MEMWB: resultsrc=01, regwrite=1, then FETCH.
REQ-012 MEMWRITE: memreq=1, memwrite=1, adrsrc=1, held every cycle until memready=1, then FETCH.
REQ-013 EXECUTER: alusrca=10, alusrcb=00, funct decode; EXECUTEI: alusrca=10, alusrcb=01, funct decode; both then ALUWB.
REQ-014 ALUWB: resultsrc=00, regwrite=1, then FETCH.
REQ-015 JAL: alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1 (PC=target, ALUOut=OldPC+4), then ALUWB.
REQ-016 JALR: alusrca=10, alusrcb=01, add, then JALRPC; JALRPC: identical controls to JAL, then ALUWB.
REQ-017 BRANCH: alusrca=10, alusrcb=00, sub, resultsrc=00, branch=1, then FETCH; taken per funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 never taken.
REQ-018 LUI: alusrca=11, alusrcb=01, add, then ALUWB; AUIPC: alusrca=01, alusrcb=01, add, then ALUWB.
REQ-019 pcwrite = (branch & taken) | pcupdate, combinational from state and flags.
REQ-020 alucontrol: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra; funct decode maps funct3 000 to sub only when op[5]=1 and funct7b5=1, 101 to sra when funct7b5=1.
REQ-021 immsrc derives from op alone: loads, OP-IMM, JALR I; stores S; branches B; JAL J; LUI/AUIPC U; else 000.
REQ-022 TRAP: all strobes 0, illegal=1, hold until reset.
REQ-023 Outputs not stated for a state SHALL be 0.

Reset
REQ-024 reset low forces state=FETCH and illegal=0 immediately, independent of clk.
REQ-025 While reset low, pcwrite, irwrite, regwrite, memwrite, memreq SHALL be 0; all other outputs take FETCH values.
REQ-026 Reset asserted mid-access (MEMREAD/MEMWRITE wait) abandons the access; first cycle after release is FETCH.

Configuration
REQ-027 Macro MC_BRANCH_EXT_EN defined: funct3 001/100/101/110/111 branches per REQ-017.
REQ-028 Macro undefined: BRANCH taken only for funct3=000 with zero=1; DECODE sends op 1100011 with funct3!=000 to TRAP; lt/ltu ignored.

Verification
REQ-029 Reset low 2 cycles, release, memready=0 for 3 cycles then 1 -> state FETCH 4 cycles, irwrite=pcwrite=1 only in 4th, then DECODE.
REQ-030 lw (op 0000011), memready=1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; regwrite=1 only in MEMWB with resultsrc=01.
REQ-031 sw with memready low 2 cycles in MEMWRITE -> memwrite=1 for 3 consecutive cycles, then FETCH.
REQ-032 bne (funct3 001) zero=0 -> pcwrite=1 in BRANCH; zero=1 -> pcwrite=0; macro undefined -> state TRAP, illegal=1.
REQ-033 jalr (op 1100111) -> DECODE,JALR,JALRPC,ALUWB,FETCH; pcwrite=1 in JALRPC only; regwrite=1 in ALUWB.
REQ-034 op 1111111 -> TRAP, illegal=1 held 10 cycles; reset low -> FETCH, illegal=0 asynchronously.
